lagarto_dcache_req_sched: RTL
=============================

Name: lagarto_dcache_req_sched

Overview:
- Single-outstanding load/store sequencer between the Lagarto memory stage and the L1 dcache load/store request ports.
- Accepts one decoded memory op and waits for DTLB translation.
- Drives the load path (request, tag phase, response wait) or the store path (request until grant).
- Handles kills at every stage and reports completion or a translation timeout to the core.

Parameters:
- TLB_TIMEOUT, 64, cycles in XLATE without dtlb_hit_i before a timeout exception is raised (≥2).
- TMO_W, $clog2(TLB_TIMEOUT), width of the timeout counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- req_valid_i  in  1  memory op offered by the core.
- req_is_load_i  in  1  op is a load (LD/LW/LWU/LH/LHU/LB/LBU).
- req_is_store_i  in  1  op is a store (SD/SW/SH/SB).
- req_kill_i  in  1  flush of the in-flight op.
- req_ready_o  out  1  scheduler idle and able to accept.
- dtlb_req_o  out  1  translation request.
- dtlb_hit_i  in  1  translation valid this cycle.
- ld_req_valid_o  out  1  load index-phase request.
- ld_gnt_i  in  1  dcache accepted the load request.
- ld_tag_valid_o  out  1  physical tag valid (one-cycle tag phase).
- ld_kill_o  out  1  kill of the load in its tag phase.
- ld_resp_valid_i  in  1  load data returned.
- st_req_valid_o  out  1  store request (we implied).
- st_gnt_i  in  1  dcache accepted the store.
- done_o  out  1  one-cycle pulse: op completed.
- xcpt_tmo_o  out  1  accompanies done_o when translation timed out.
- busy_o  out  1  state ≠ IDLE.

Behaviour:
- Reset: state=IDLE, counter=0; all outputs 0, including req_ready_o while rst_i=1. Reset mid-operation abandons the op with no done_o; any late ld_resp_valid_i is ignored.
- Outputs are Moore-decoded from registered state. req_ready_o=1 only in IDLE with rst_i=0.
- IDLE: accept when req_valid_i & (load XOR store) & !req_kill_i; latch the type and go to XLATE. Load&store both set, or neither set: not accepted, stay in IDLE.
- XLATE: dtlb_req_o=1; counter increments each cycle.
  - dtlb_hit_i → LD_REQ (load) or ST_REQ (store); counter cleared.
  - counter==TLB_TIMEOUT-1 with no hit → DONE with xcpt_tmo latched. A hit in that same cycle wins.
- LD_REQ: ld_req_valid_o=1 and held until ld_gnt_i, then LD_TAG.
- LD_TAG: ld_tag_valid_o=1 for exactly one cycle, then LD_WAIT.
- LD_WAIT: on ld_resp_valid_i → DONE.
- ST_REQ: st_req_valid_o=1 and held until st_gnt_i, then DONE.
- DONE: done_o=1 for one cycle, xcpt_tmo_o=latched flag; then IDLE. A new op is accepted earliest the following cycle.
- Kill rules (req_kill_i sampled each cycle):
  - XLATE, LD_REQ, ST_REQ before grant → IDLE; no done_o. A kill coincident with a grant: the grant is honoured, the op is treated as issued, and the kill rules for the next state apply.
  - LD_TAG → ld_kill_o=1 alongside ld_tag_valid_o, then IDLE (cache drops the response).
  - LD_WAIT → DRAIN: wait for ld_resp_valid_i, discard it, go to IDLE; no done_o. Kill plus response in the same cycle → IDLE directly.
  - ST after grant: not killable.
- Kill and accept in the same cycle: the op is not accepted.
- Nominal latency, load with immediate hit and grant: accept at t0, XLATE t1, LD_REQ t2, LD_TAG t3, LD_WAIT t4; response at tN gives done_o at tN+1.
- Nominal latency, store: done_o at t3.

Decomposition:
- drac_pkg gains ldst_sched_state_t (IDLE, XLATE, LD_REQ, LD_TAG, LD_WAIT, DRAIN, ST_REQ, DONE) and the default constant DCACHE_TLB_TIMEOUT=64.
- No sub-module: one FSM plus the timeout counter, in a single file.
- Load/store classification from instr_type stays with the caller.

Test Plan:
- Load, hit at t1, gnt at t2, resp at t7 → ld_req_valid_o at t2 only, ld_tag_valid_o at t3, done_o at t8, xcpt_tmo_o=0.
- Store, hit at t1, st_gnt_i held low t2–t5 and high at t6 → st_req_valid_o high t2–t6, done_o at t7.
- Load, no hit, TLB_TIMEOUT=8 → dtlb_req_o high 8 cycles, then done_o=1 with xcpt_tmo_o=1; next accept succeeds.
- Kill in each of XLATE, LD_TAG, LD_WAIT (resp 3 cycles later), ST_REQ → respectively: IDLE next cycle; ld_kill_o=1 alongside ld_tag_valid_o; busy_o until the discarded resp; IDLE. No done_o in any case.
- req_is_load_i=req_is_store_i=1 with req_valid_i → req_ready_o stays 1, dtlb_req_o stays 0.
- rst_i asserted in LD_WAIT, resp arrives 2 cycles after release → all outputs 0 during reset; late resp yields no done_o.

Source files
------------

// File: rtl/drac_pkg.sv
// Shared Lagarto (DRAC) core types used by the L1 dcache load/store request scheduler.
package drac_pkg;

    // Default number of XLATE cycles without a DTLB hit before a timeout is reported.
    localparam int unsigned DCACHE_TLB_TIMEOUT = 64;

    typedef enum logic [2:0] {
        IDLE,
        XLATE,
        LD_REQ,
        LD_TAG,
        LD_WAIT,
        DRAIN,
        ST_REQ,
        DONE
    } ldst_sched_state_t;

endpackage

// File: rtl/lagarto_dcache_req_sched.sv
// Single-outstanding load/store sequencer between the Lagarto memory stage and the
// L1 dcache load/store request ports: waits for DTLB translation, issues, completes or flushes.
module lagarto_dcache_req_sched
    import drac_pkg::*;
#(
    parameter int unsigned TLB_TIMEOUT = DCACHE_TLB_TIMEOUT,
    parameter int unsigned TMO_W       = $clog2(TLB_TIMEOUT)
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_valid_i,
    input  logic req_is_load_i,
    input  logic req_is_store_i,
    input  logic req_kill_i,
    output logic req_ready_o,
    output logic dtlb_req_o,
    input  logic dtlb_hit_i,
    output logic ld_req_valid_o,
    input  logic ld_gnt_i,
    output logic ld_tag_valid_o,
    output logic ld_kill_o,
    input  logic ld_resp_valid_i,
    output logic st_req_valid_o,
    input  logic st_gnt_i,
    output logic done_o,
    output logic xcpt_tmo_o,
    output logic busy_o
);

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TLB_TIMEOUT - 1);

    ldst_sched_state_t r_state;
    logic [TMO_W-1:0]  r_cnt;
    logic              r_is_load;
    logic              r_xcpt_tmo;
    logic              w_accept;
    logic              w_run;

    assign w_accept = req_valid_i && (req_is_load_i ^ req_is_store_i) && !req_kill_i;

    // NOTE: all state lives in one clocked block written only with non-blocking
    // assignments, so every branch sees the pre-edge values of r_state and r_cnt.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_is_load  <= 1'b0;
            r_xcpt_tmo <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_state    <= XLATE;
                        r_is_load  <= req_is_load_i;
                        r_xcpt_tmo <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                XLATE: begin
                    // Kill beats a hit; a hit beats the timeout on the last cycle.
                    if (req_kill_i) begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end else if (dtlb_hit_i) begin
                        r_state <= r_is_load ? LD_REQ : ST_REQ;
                        r_cnt   <= '0;
                    end else if (r_cnt == TMO_LAST) begin
                        r_state    <= DONE;
                        r_xcpt_tmo <= 1'b1;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                LD_REQ: begin
                    if (ld_gnt_i) begin
                        r_state <= LD_TAG;
                    end else if (req_kill_i) begin
                        r_state <= IDLE;
                    end
                end
                LD_TAG: begin
                    r_state <= req_kill_i ? IDLE : LD_WAIT;
                end
                LD_WAIT: begin
                    if (ld_resp_valid_i) begin
                        r_state <= req_kill_i ? IDLE : DONE;
                    end else if (req_kill_i) begin
                        r_state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (ld_resp_valid_i) begin
                        r_state <= IDLE;
                    end
                end
                ST_REQ: begin
                    // Once granted the store is committed; a coincident kill is ignored.
                    if (st_gnt_i) begin
                        r_state <= DONE;
                    end else if (req_kill_i) begin
                        r_state <= IDLE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode the registered state and are forced low while reset is held,
    // including the cycle in which reset first arrives mid-operation.
    assign w_run = !rst_i;

    assign req_ready_o    = w_run && (r_state == IDLE);
    assign dtlb_req_o     = w_run && (r_state == XLATE);
    assign ld_req_valid_o = w_run && (r_state == LD_REQ);
    assign ld_tag_valid_o = w_run && (r_state == LD_TAG);
    assign ld_kill_o      = w_run && (r_state == LD_TAG) && req_kill_i;
    assign st_req_valid_o = w_run && (r_state == ST_REQ);
    assign done_o         = w_run && (r_state == DONE);
    assign xcpt_tmo_o     = w_run && (r_state == DONE) && r_xcpt_tmo;
    assign busy_o         = w_run && (r_state != IDLE);

endmodule
